multicycle_sequencer: RTL

- Parametrised control/PC sequencer for the multi-cycle RISC-V core; replaces fixed wait-state control with a req/ready memory handshake.
- Adds skipping of the memory phase for non-memory instructions, a bus timeout, misaligned-fetch trapping, single-step debug mode and a retired-instruction counter.
- Sits between the instruction decoder, ALU, branch unit, register file and the memory port.

---
 rtl/multicycle_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RISC-V control/PC sequencer with req/ready memory port
module multicycle_sequencer #(
  parameter int                   WORD_SIZE   = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
  parameter int                   MEM_TIMEOUT = 16,
  parameter int                   INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 decode_error,
  input  logic                 jump,
  input  logic                 jal_or_jalr,
  input  logic                 branch,
  input  logic                 branch_taken,
  input  logic                 mem_read,
  input  logic [1:0]           mem_write_size,
  input  logic [2:0]           load_size,
  input  logic [WORD_SIZE-1:0] immediate,
  input  logic [WORD_SIZE-1:0] rv1,
  input  logic [WORD_SIZE-1:0] rv2,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 mem_ready,
  input  logic                 mem_error,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [1:0]           mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 reg_we,
  output logic [WORD_SIZE-1:0] reg_wdata,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state,
  output logic [1:0]           err_code
);

  typedef enum logic [3:0] {
    S_START        = 4'd0,
    S_FETCH        = 4'd1,
    S_WAIT_FETCH   = 4'd2,
    S_DECODE       = 4'd3,
    S_EXECUTE      = 4'd4,
    S_MEM_ACCESS   = 4'd5,
    S_WAIT_MEM     = 4'd6,
    S_WRITEBACK    = 4'd7,
    S_HALT_STEP    = 4'd8,
    S_MEM_ERROR    = 4'd13,
    S_DECODE_ERROR = 4'd14,
    S_FSM_ERROR    = 4'd15
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t                 state_q, state_d;
  logic                   err_set;
  logic [1:0]             err_val;
  logic [CW-1:0]          wait_cnt;
  logic                   in_wait;
  logic                   timeout_hit;
  logic [WORD_SIZE-1:0]   load_data;
  logic [WORD_SIZE-1:0]   load_ext;
  logic [WORD_SIZE-1:0]   pc_next;

  assign state       = state_q;
  assign in_wait     = (state_q == S_WAIT_FETCH) || (state_q == S_WAIT_MEM);
  // wait_cnt holds the number of ready-low cycles already seen in this wait
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign reg_we      = (state_q == S_WRITEBACK);
  assign retire      = (state_q == S_WRITEBACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_START;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_val = 2'b00;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (pc[1:0] != 2'b00) begin
          state_d = S_MEM_ERROR;
          err_set = 1'b1;
          err_val = 2'b11;
        end else begin
          state_d = S_WAIT_FETCH;
        end
      end
      S_WAIT_FETCH, S_WAIT_MEM: begin
        if ((mem_ready && mem_error) || timeout_hit) begin
          state_d = S_MEM_ERROR;
          err_set = 1'b1;
          err_val = 2'b10;
        end else if (mem_ready) begin
          if (state_q == S_WAIT_FETCH) state_d = S_DECODE;
          else                         state_d = S_WRITEBACK;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (decode_error) begin
          state_d = S_DECODE_ERROR;
          err_set = 1'b1;
          err_val = 2'b01;
        end else if (mem_read || (mem_write_size != 2'b00)) begin
          state_d = S_MEM_ACCESS;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM_ACCESS: state_d = S_WAIT_MEM;
      S_WRITEBACK: begin
        if (step_mode) state_d = S_HALT_STEP;
        else           state_d = S_FETCH;
      end
      S_HALT_STEP: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
      S_DECODE_ERROR, S_MEM_ERROR, S_FSM_ERROR: state_d = state_q;
      default: state_d = S_FSM_ERROR;
    endcase
  end

  always_comb begin
    case (load_size)
      3'b000:  load_ext = {{(WORD_SIZE-8){load_data[7]}}, load_data[7:0]};
      3'b001:  load_ext = {{(WORD_SIZE-16){load_data[15]}}, load_data[15:0]};
      3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}}, load_data[7:0]};
      3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, load_data[15:0]};
      default: load_ext = load_data;
    endcase
  end

  always_comb begin
    reg_wdata = '0;
    if (state_q == S_WRITEBACK) begin
      if (jump)          reg_wdata = pc + WORD_SIZE'(4);
      else if (mem_read) reg_wdata = load_ext;
      else               reg_wdata = alu_result;
    end
  end

  always_comb begin
    pc_next = pc + WORD_SIZE'(4);
    if (jump && jal_or_jalr)         pc_next = pc + immediate;
    else if (jump)                   pc_next = (rv1 + immediate) & ~WORD_SIZE'(1);
    else if (branch && branch_taken) pc_next = pc + immediate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 2'b00;
      mem_wdata   <= '0;
      instruction <= '0;
      pc          <= RESET_PC;
      instret     <= '0;
      err_code    <= 2'b00;
      wait_cnt    <= '0;
      load_data   <= '0;
    end else begin
      // request stays up exactly while the FSM sits in a wait state
      mem_req <= (state_d == S_WAIT_FETCH) || (state_d == S_WAIT_MEM);
      if (state_q == S_FETCH && state_d == S_WAIT_FETCH) begin
        mem_addr <= pc;
        mem_we   <= 2'b00;
      end
      if (state_q == S_MEM_ACCESS) begin
        mem_addr  <= alu_result;
        mem_we    <= mem_write_size;
        mem_wdata <= rv2;
      end
      if (state_q == S_FETCH || state_q == S_MEM_ACCESS) wait_cnt <= '0;
      else if (in_wait && !mem_ready)                  wait_cnt <= wait_cnt + CW'(1);
      if (state_q == S_WAIT_FETCH && mem_ready && !mem_error) instruction <= mem_rdata;
      if (state_q == S_WAIT_MEM && mem_ready && !mem_error)   load_data <= mem_rdata;
      if (err_set) err_code <= err_val;
      if (state_q == S_WRITEBACK) begin
        pc      <= pc_next;
        instret <= instret + INSTRET_W'(1);
      end
    end
  end

endmodule
